// File: rtl/flag_cond_unit_pkg.sv
// rtl/flag_cond_unit_pkg.sv - shared flag layout and ARM condition encodings
// Purpose: flag vector width, ALU flag bit positions and 4-bit cond codes,
//          shared by the flag/condition unit and the branch unit.
// Ports:   none (package).
package flag_cond_unit_pkg;

    localparam int FLAGSW = 4;

    // ALU flagsout bit order
    localparam int Z_i = 0;
    localparam int C_i = 1;
    localparam int N_i = 2;
    localparam int V_i = 3;

    typedef logic [FLAGSW-1:0] flags_t;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/flag_cond_unit_if.sv
// rtl/flag_cond_unit_if.sv - issue, write-back and status bundle of the flag unit
// Purpose: groups the issue handshake, execute flag write-back, flush and
//          flag/condition status outputs.
// Ports:   master = issue/execute side, slave = flag_cond_unit.
interface flag_cond_unit_if;

    logic                       iss_valid;
    logic                       iss_ready;
    logic [3:0]                 iss_cond;
    logic                       iss_setflags;
    logic                       wb_valid;
    flag_cond_unit_pkg::flags_t wb_flags;
    logic                       flush;
    flag_cond_unit_pkg::flags_t cpsr_flags;
    logic                       pass_valid;
    logic                       pass;
    logic [2:0]                 pend_cnt;
    logic                       err;

    modport master (
        output iss_valid, iss_cond, iss_setflags, wb_valid, wb_flags, flush,
        input  iss_ready, cpsr_flags, pass_valid, pass, pend_cnt, err
    );

    modport slave (
        input  iss_valid, iss_cond, iss_setflags, wb_valid, wb_flags, flush,
        output iss_ready, cpsr_flags, pass_valid, pass, pend_cnt, err
    );

endinterface

// File: rtl/flag_cond_unit_cond_eval.sv
// rtl/flag_cond_unit_cond_eval.sv - combinational ARM condition evaluator
// Purpose: decides whether a cond field passes against a flag vector.
// Ports:   cond  in  4  ARM cond field
//          flags in  4  flag vector, ALU bit order
//          pass  out 1  condition satisfied (NV never passes)
module cond_eval
    import flag_cond_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  flags_t     flags,
    output logic       pass
);

    logic z, c, n, v;

    assign z = flags[Z_i];
    assign c = flags[C_i];
    assign n = flags[N_i];
    assign v = flags[V_i];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_cond_unit.sv
// rtl/flag_cond_unit.sv - NZCV flag register, flag dependency tracking and condition check
// Purpose: holds committed flags, counts outstanding flag-setting instructions,
//          stalls dependent issue and evaluates the cond field of accepted
//          instructions with same-cycle write-back bypass.
// Ports:   clk   in  1  clock
//          reset in  1  asynchronous active-high reset
//          bus   slave modport of flag_cond_unit_if
module flag_cond_unit
    import flag_cond_unit_pkg::*;
#(
    parameter int MAXPEND = 3
) (
    input  logic              clk,
    input  logic              reset,
    flag_cond_unit_if.slave   bus
);

    localparam logic [2:0] MAX_CNT = 3'(MAXPEND);

    logic       needs;
    logic       wb_at_zero;
    logic [2:0] eff;
    logic       accept;
    logic [2:0] pend_next;
    flags_t     eval_flags;
    logic       cond_pass;

    assign needs      = (bus.iss_cond != COND_AL);
    assign wb_at_zero = bus.wb_valid && (bus.pend_cnt == 3'd0);

    // Count as if this cycle's write-back had already retired, so a
    // dependent instruction can issue alongside its resolving write-back.
    assign eff = (bus.wb_valid && !wb_at_zero) ? bus.pend_cnt - 3'd1 : bus.pend_cnt;

    assign bus.iss_ready = !bus.flush
                         && (!needs || eff == 3'd0)
                         && (!bus.iss_setflags || eff < MAX_CNT);

    assign accept    = bus.iss_valid && bus.iss_ready;
    assign pend_next = eff + {2'b00, accept && bus.iss_setflags};

    assign eval_flags = bus.wb_valid ? bus.wb_flags : bus.cpsr_flags;

    cond_eval u_cond_eval (
        .cond  (bus.iss_cond),
        .flags (eval_flags),
        .pass  (cond_pass)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.cpsr_flags <= '0;
            bus.pass_valid <= 1'b0;
            bus.pass       <= 1'b0;
            bus.pend_cnt   <= 3'd0;
            bus.err        <= 1'b0;
        end else begin
            // Write-back commits even during flush or with nothing pending.
            if (bus.wb_valid) begin
                bus.cpsr_flags <= bus.wb_flags;
            end
            if (wb_at_zero) begin
                bus.err <= 1'b1;
            end
            if (bus.flush) begin
                bus.pend_cnt   <= 3'd0;
                bus.pass_valid <= 1'b0;
            end else begin
                bus.pend_cnt   <= pend_next;
                bus.pass_valid <= accept;
                if (accept) begin
                    bus.pass <= cond_pass;
                end
            end
        end
    end

endmodule

// File: tb/tb_flag_cond_unit.sv
// tb/tb_flag_cond_unit.sv - self-checking bench for flag_cond_unit
module tb_flag_cond_unit;
    import flag_cond_unit_pkg::*;

    localparam int MAXPEND = 3;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [3:0] m_flags;
    logic [2:0] m_pend;
    logic       m_err;
    logic       exp_q[$];

    flag_cond_unit_if bus ();

    flag_cond_unit #(.MAXPEND(MAXPEND)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: even codes test a base predicate, odd codes invert it.
    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic z, cy, n, v, r;
        z = f[0]; cy = f[1]; n = f[2]; v = f[3];
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy & ~z;
            3'd5: r = ~(n ^ v);
            3'd6: r = ~z & ~(n ^ v);
            default: r = 1'b1;
        endcase
        return c[0] ? ~r : r;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cpsr"}, bus.cpsr_flags, 8'h0);
        check({tag, "_pv"},   bus.pass_valid, 8'h0);
        check({tag, "_pass"}, bus.pass,       8'h0);
        check({tag, "_pend"}, bus.pend_cnt,   8'h0);
        check({tag, "_err"},  bus.err,        8'h0);
        check({tag, "_rdy"},  bus.iss_ready,  8'h1);
    endtask

    // One clock: drive at posedge+1, check ready at negedge, check state at next posedge+1.
    task automatic cycle(input logic v, input logic [3:0] c, input logic sf,
                         input logic wbv, input logic [3:0] wbf, input logic fl);
        logic [2:0] eff;
        logic       rdy;
        logic       acc;
        logic       e;
        bus.iss_valid    = v;
        bus.iss_cond     = c;
        bus.iss_setflags = sf;
        bus.wb_valid     = wbv;
        bus.wb_flags     = wbf;
        bus.flush        = fl;
        @(negedge clk);
        eff = (wbv && m_pend != 3'd0) ? m_pend - 3'd1 : m_pend;
        rdy = !fl && (c == 4'hE || eff == 3'd0) && (!sf || int'(eff) < MAXPEND);
        check("iss_ready", bus.iss_ready, rdy);
        acc = v && rdy;
        if (acc) exp_q.push_back(cond_ref(c, wbv ? wbf : m_flags));
        @(posedge clk);
        #1;
        if (wbv && m_pend == 3'd0) m_err = 1'b1;
        if (wbv) m_flags = wbf;
        m_pend = fl ? 3'd0 : eff + {2'b00, acc && sf};
        check("pass_valid", bus.pass_valid, acc);
        if (acc && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pass", bus.pass, e);
        end
        check("pend_cnt", bus.pend_cnt, m_pend);
        check("cpsr_flags", bus.cpsr_flags, m_flags);
        check("err", bus.err, m_err);
    endtask

    task automatic model_reset();
        m_flags = 4'h0;
        m_pend  = 3'd0;
        m_err   = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        reset            = 1'b1;
        bus.iss_valid    = 1'b0;
        bus.iss_cond     = COND_EQ;
        bus.iss_setflags = 1'b0;
        bus.wb_valid     = 1'b0;
        bus.wb_flags     = 4'h0;
        bus.flush        = 1'b0;
        #3;
        check_idle_outputs("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // EQ with nothing pending, Z=0
        cycle(1, COND_EQ, 0, 0, 4'h0, 0);

        // CMP, then NE stalls until its write-back, which bypasses
        cycle(1, COND_AL, 1, 0, 4'h0, 0);
        cycle(1, COND_NE, 0, 0, 4'h0, 0);
        cycle(1, COND_NE, 0, 0, 4'h0, 0);
        cycle(1, COND_NE, 0, 1, 4'b0001, 0);

        // Fill to MAXPEND, then setflags issue only with a same-cycle write-back
        for (int i = 0; i < MAXPEND; i++) cycle(1, COND_AL, 1, 0, 4'h0, 0);
        cycle(1, COND_AL, 1, 0, 4'h0, 0);
        cycle(1, COND_AL, 1, 1, 4'b1010, 0);
        for (int i = 0; i < MAXPEND; i++) cycle(0, COND_AL, 0, 1, 4'(i + 5), 0);

        // Sweep: cond 0 via bypass at pend 1, the rest from committed flags
        for (int f = 0; f < 16; f++) begin
            cycle(1, COND_AL, 1, 0, 4'h0, 0);
            cycle(1, 4'h0, 0, 1, 4'(f), 0);
            for (int c = 1; c < 16; c++) cycle(1, 4'(c), 0, 0, 4'h0, 0);
        end

        // Flush with write-back at pend 2
        cycle(1, COND_AL, 1, 0, 4'h0, 0);
        cycle(1, COND_AL, 1, 0, 4'h0, 0);
        cycle(1, COND_AL, 0, 1, 4'b1100, 1);
        cycle(1, COND_MI, 0, 0, 4'h0, 0);

        // Write-back with nothing pending: sticky err
        cycle(0, COND_AL, 0, 1, 4'b0110, 0);
        for (int i = 0; i < 3; i++) cycle(1, COND_GE, 0, 0, 4'h0, 0);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset mid-cycle
        cycle(1, COND_AL, 1, 1, 4'b0111, 0);
        cycle(1, COND_AL, 1, 0, 4'h0, 0);
        bus.iss_valid    = 1'b1;
        bus.iss_cond     = COND_AL;
        bus.iss_setflags = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        model_reset();
        bus.iss_valid    = 1'b0;
        bus.iss_setflags = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(1, COND_EQ, 0, 0, 4'h0, 0);
        cycle(1, COND_NE, 0, 0, 4'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
